// File: rtl/pipe_stall_ctrl.sv
// PC / IF-ID / ID-EX consumer of the hazard-unit handshake, with protocol and stall-length policing.
// Optional performance counters are enabled by defining PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 32,
  parameter int                 CTRL_W    = 8,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int                 MAX_STALL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               pc_write,
  input  logic               if_id_write,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic [3:0]         id_rd,
  output logic [PC_W-1:0]    pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               id_ex_valid,
  output logic [CTRL_W-1:0]  id_ex_ctrl,
  output logic [3:0]         id_ex_rd,
  output logic [PC_W-1:0]    id_ex_pc,
  output logic               proto_err,
  output logic               stall_timeout,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  logic       stall_cycle;
  logic       triple_legal;
  logic [7:0] stall_run;

  // A redirect overrides a simultaneous stall, so such a cycle is not a stall cycle.
  assign stall_cycle  = stall && !redirect_valid;
  assign triple_legal = ({stall, pc_write, if_id_write} == 3'b011) ||
                        ({stall, pc_write, if_id_write} == 3'b100);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (pc_write) begin
      pc <= pc + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= rst ? '0 : if_id_pc;
    end else if (if_id_write) begin
      if_id_valid <= 1'b1;
      if_id_instr <= imem_instr;
      if_id_pc    <= pc;
    end
  end

  // Bubbles carry rd=0 so the hazard unit never sees a false dependency on them.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_valid <= 1'b0;
      id_ex_ctrl  <= '0;
      id_ex_rd    <= '0;
      id_ex_pc    <= '0;
    end else if (redirect_valid || stall) begin
      id_ex_valid <= 1'b0;
      id_ex_ctrl  <= '0;
      id_ex_rd    <= '0;
    end else begin
      id_ex_valid <= if_id_valid;
      id_ex_ctrl  <= id_ctrl;
      id_ex_rd    <= id_rd;
      id_ex_pc    <= if_id_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err     <= 1'b0;
      stall_timeout <= 1'b0;
      stall_run     <= '0;
    end else begin
      if (!redirect_valid && !triple_legal) begin
        proto_err <= 1'b1;
      end
      if (stall_cycle) begin
        if (stall_run != 8'hFF) begin
          stall_run <= stall_run + 8'd1;
        end
        if (int'(stall_run) >= MAX_STALL) begin
          stall_timeout <= 1'b1;
        end
      end else begin
        stall_run <= '0;
      end
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_cycle && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_valid && flush_cnt_q != 32'hFFFF_FFFF) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-level reference model predicts every output,
// a separate monitor pops and compares after each rising edge.
module tb_pipe_stall_ctrl;

  typedef struct {
    logic [15:0] pc;
    logic        if_v;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        ex_v;
    logic [7:0]  ex_ctrl;
    logic [3:0]  ex_rd;
    logic [15:0] ex_pc;
    logic        perr;
    logic        tmo;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  localparam int MAX_STALL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, pc_write = 1'b1, if_id_write = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [31:0] imem_instr = '0;
  logic [7:0]  id_ctrl = '0;
  logic [3:0]  id_rd = '0;

  logic [15:0] pc, if_id_pc, id_ex_pc;
  logic        if_id_valid, id_ex_valid, proto_err, stall_timeout;
  logic [31:0] if_id_instr, stall_cnt, flush_cnt;
  logic [7:0]  id_ex_ctrl;
  logic [3:0]  id_ex_rd;

  exp_t exp_q[$];
  exp_t mdl;
  int   mdl_run = 0;
  int   checks = 0;
  int   errors = 0;

  pipe_stall_ctrl #(.MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem_instr(imem_instr),
    .id_ctrl(id_ctrl), .id_rd(id_rd), .pc(pc), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .id_ex_valid(id_ex_valid),
    .id_ex_ctrl(id_ex_ctrl), .id_ex_rd(id_ex_rd), .id_ex_pc(id_ex_pc),
    .proto_err(proto_err), .stall_timeout(stall_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_state();
    exp_t e;
    e.pc = 16'h0; e.if_v = 1'b0; e.if_instr = 32'h13; e.if_pc = 16'h0;
    e.ex_v = 1'b0; e.ex_ctrl = 8'h0; e.ex_rd = 4'h0; e.ex_pc = 16'h0;
    e.perr = 1'b0; e.tmo = 1'b0; e.scnt = 32'h0; e.fcnt = 32'h0;
    return e;
  endfunction

  // Drives one cycle of inputs at the falling edge and predicts the state after the next rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic pw, input logic iw,
                               input logic rv, input logic [15:0] rpc);
    exp_t nx;
    logic [31:0] instr;
    logic [7:0]  ctrl;
    logic [3:0]  rd;
    bit          legal, stall_cyc;
    @(negedge clk);
    instr = $urandom;
    ctrl  = 8'($urandom);
    rd    = 4'($urandom);
    rst = r; stall = s; pc_write = pw; if_id_write = iw;
    redirect_valid = rv; redirect_pc = rpc;
    imem_instr = instr; id_ctrl = ctrl; id_rd = rd;

    nx = mdl;
    legal     = ({s, pw, iw} == 3'b011) || ({s, pw, iw} == 3'b100);
    stall_cyc = s && !rv;
    if (r) begin
      nx = reset_state();
      mdl_run = 0;
    end else begin
      if (rv)      nx.pc = rpc;
      else if (pw) nx.pc = 16'((int'(mdl.pc) + 4) % 65536);

      if (rv) begin
        nx.if_v = 1'b0; nx.if_instr = 32'h13;
      end else if (iw) begin
        nx.if_v = 1'b1; nx.if_instr = instr; nx.if_pc = mdl.pc;
      end

      if (rv || s) begin
        nx.ex_v = 1'b0; nx.ex_ctrl = 8'h0; nx.ex_rd = 4'h0;
      end else begin
        nx.ex_v = mdl.if_v; nx.ex_ctrl = ctrl; nx.ex_rd = rd; nx.ex_pc = mdl.if_pc;
      end

      if (!rv && !legal) nx.perr = 1'b1;
      if (stall_cyc) begin
        if (mdl_run >= MAX_STALL) nx.tmo = 1'b1;
        mdl_run = mdl_run + 1;
      end else begin
        mdl_run = 0;
      end
`ifdef PIPE_STALL_PERF_EN
      if (stall_cyc && mdl.scnt != 32'hFFFF_FFFF) nx.scnt = mdl.scnt + 1;
      if (rv && mdl.fcnt != 32'hFFFF_FFFF)        nx.fcnt = mdl.fcnt + 1;
`endif
    end
    mdl = nx;
    exp_q.push_back(nx);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("pc",            64'(pc),            64'(e.pc));
    cmp("if_id_valid",   64'(if_id_valid),   64'(e.if_v));
    cmp("if_id_instr",   64'(if_id_instr),   64'(e.if_instr));
    cmp("if_id_pc",      64'(if_id_pc),      64'(e.if_pc));
    cmp("id_ex_valid",   64'(id_ex_valid),   64'(e.ex_v));
    cmp("id_ex_ctrl",    64'(id_ex_ctrl),    64'(e.ex_ctrl));
    cmp("id_ex_rd",      64'(id_ex_rd),      64'(e.ex_rd));
    cmp("id_ex_pc",      64'(id_ex_pc),      64'(e.ex_pc));
    cmp("proto_err",     64'(proto_err),     64'(e.perr));
    cmp("stall_timeout", 64'(stall_timeout), 64'(e.tmo));
    cmp("stall_cnt",     64'(stall_cnt),     64'(e.scnt));
    cmp("flush_cnt",     64'(flush_cnt),     64'(e.fcnt));
  endtask

  // Monitor: every rising edge presents a new output set; compare it against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic run(input logic s, input logic pw, input logic iw, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, s, pw, iw, 1'b0, 16'h0);
  endtask

  initial begin
    int wait_cycles;
    logic r, rv, s, pw, iw;
    int sel;
    mdl = reset_state();

    // Reset for two cycles, then free-run 0,4,8, one load-use stall at pc=8, resume.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    run(1'b0, 1'b1, 1'b1, 2);
    run(1'b1, 1'b0, 1'b0, 1);
    run(1'b0, 1'b1, 1'b1, 3);

    // Redirect together with a stall request: redirect wins, no protocol error.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0040);
    run(1'b0, 1'b1, 1'b1, 2);

    // Illegal triple sets sticky proto_err.
    run(1'b1, 1'b1, 1'b0, 1);
    run(1'b0, 1'b1, 1'b1, 3);

    // Two stalls are legal, the third run cycle flags a timeout.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    run(1'b1, 1'b0, 1'b0, 2);
    run(1'b0, 1'b1, 1'b1, 2);
    run(1'b1, 1'b0, 1'b0, 3);
    run(1'b0, 1'b1, 1'b1, 2);

    // Five stall cycles and three redirects for the performance counters.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 1'b0, 1'b0, 1);
      run(1'b0, 1'b1, 1'b1, 1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'($urandom));
      run(1'b0, 1'b1, 1'b1, 1);
    end

    // Randomized traffic: mostly legal handshakes, some redirects, rare illegal triples and resets.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 99) < 10);
      sel = $urandom_range(0, 99);
      if (sel < 65)      {s, pw, iw} = 3'b011;
      else if (sel < 95) {s, pw, iw} = 3'b100;
      else               {s, pw, iw} = 3'($urandom);
      applyStimulus(r, s, pw, iw, rv, 16'($urandom));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
